// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB globals: widths, requester count and requester index constants.
// The issue units use the same requester index constants.
package cdb_arbiter_pkg;

  localparam int CDB_N_REQ  = 4;
  localparam int CDB_W_DATA = 32;
  localparam int CDB_W_TAG  = 6;

  localparam int CDB_REQ_INT  = 0;
  localparam int CDB_REQ_LS   = 1;
  localparam int CDB_REQ_MULT = 2;
  localparam int CDB_REQ_DIV  = 3;

  // Pointer width; at least one bit even for a single requester.
  function automatic int cdb_ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_pick.sv
// Combinational one-hot picker: the first requester at or after ptr_i wins, wrapping.
// REVERSE flips the search order so that, with ptr tied to 0, the highest index wins.
module cdb_arb_pick
  import cdb_arbiter_pkg::*;
#(
  parameter int N       = CDB_N_REQ,
  parameter int PW      = cdb_ptr_w(CDB_N_REQ),
  parameter bit REVERSE = 1'b0
) (
  input  logic          rst_i,
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o
);

  logic [N-1:0] req_ord;
  logic [N-1:0] gnt_ord;
  logic [PW:0]  sum;
  logic         found;

  for (genvar g = 0; g < N; g++) begin : g_ord
    if (REVERSE) begin : g_rev
      assign req_ord[g] = req_i[N-1-g];
      assign grant_o[g] = ~rst_i & gnt_ord[N-1-g];
    end else begin : g_fwd
      assign req_ord[g] = req_i[g];
      assign grant_o[g] = ~rst_i & gnt_ord[g];
    end
  end

  always_comb begin
    gnt_ord = '0;
    found   = 1'b0;
    sum     = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_i} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      if (!found && req_ord[sum[PW-1:0]]) begin
        gnt_ord[sum[PW-1:0]] = 1'b1;
        found                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: grants one completed result per cycle and drives a registered
// broadcast. Define CDB_ARB_RR_EN for round-robin; otherwise fixed priority div>mult>ls>int.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ  = CDB_N_REQ,
  parameter int W_DATA = CDB_W_DATA,
  parameter int W_TAG  = CDB_W_TAG
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*W_TAG-1:0]  req_tag,
  input  logic [N_REQ*W_DATA-1:0] req_data,
  input  logic                    req_branch,
  input  logic                    req_taken,
  output logic [N_REQ-1:0]        grant,
  output logic                    cdb_valid,
  output logic [W_TAG-1:0]        cdb_tag,
  output logic [W_DATA-1:0]       cdb_data,
  output logic                    cdb_branch,
  output logic                    cdb_taken
);

  localparam int PW = cdb_ptr_w(N_REQ);

  logic [PW-1:0]     ptr;
  logic              any_gnt;
  logic [W_TAG-1:0]  sel_tag;
  logic [W_DATA-1:0] sel_data;

  logic              valid_q;
  logic [W_TAG-1:0]  tag_q;
  logic [W_DATA-1:0] data_q;
  logic              branch_q, taken_q;

`ifdef CDB_ARB_RR_EN
  localparam bit PICK_REV = 1'b0;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gidx;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant[i]) gidx = PW'(i);
    ptr_d = ptr_q;
    if (any_gnt) ptr_d = (gidx == PW'(N_REQ-1)) ? '0 : gidx + PW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  localparam bit PICK_REV = 1'b1;
  assign ptr = '0;
`endif

  cdb_arb_pick #(
    .N       (N_REQ),
    .PW      (PW),
    .REVERSE (PICK_REV)
  ) u_pick (
    .rst_i   (reset),
    .req_i   (req_valid),
    .ptr_i   (ptr),
    .grant_o (grant)
  );

  assign any_gnt = |grant;

  always_comb begin
    sel_tag  = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_tag  = req_tag[i*W_TAG +: W_TAG];
        sel_data = req_data[i*W_DATA +: W_DATA];
      end
    end
  end

  // Payload holds when idle; consumers qualify it with cdb_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      tag_q    <= '0;
      data_q   <= '0;
      branch_q <= 1'b0;
      taken_q  <= 1'b0;
    end else begin
      valid_q <= any_gnt;
      if (any_gnt) begin
        tag_q    <= sel_tag;
        data_q   <= sel_data;
        branch_q <= grant[CDB_REQ_INT] & req_branch;
        taken_q  <= grant[CDB_REQ_INT] & req_taken;
      end
    end
  end

  assign cdb_valid  = valid_q;
  assign cdb_tag    = tag_q;
  assign cdb_data   = data_q;
  assign cdb_branch = branch_q;
  assign cdb_taken  = taken_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter; expectations follow the build (CDB_ARB_RR_EN or fixed priority).
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int WD = 32;
  localparam int WT = 6;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*WT-1:0] req_tag;
  logic [N*WD-1:0] req_data;
  logic            req_branch, req_taken;
  logic [N-1:0]    grant;
  logic            cdb_valid;
  logic [WT-1:0]   cdb_tag;
  logic [WD-1:0]   cdb_data;
  logic            cdb_branch, cdb_taken;

  int total = 0;
  int bad   = 0;

  cdb_arbiter #(.N_REQ(N), .W_DATA(WD), .W_TAG(WT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_tag    (req_tag),
    .req_data   (req_data),
    .req_branch (req_branch),
    .req_taken  (req_taken),
    .grant      (grant),
    .cdb_valid  (cdb_valid),
    .cdb_tag    (cdb_tag),
    .cdb_data   (cdb_data),
    .cdb_branch (cdb_branch),
    .cdb_taken  (cdb_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [WT-1:0] t, input logic [WD-1:0] d);
    req_tag[i*WT +: WT] = t;
    req_data[i*WD +: WD] = d;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; req_valid = '1; req_tag = '0; req_data = '0;
    req_branch = 1'b0; req_taken = 1'b0;
    #2;
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_valid", 64'(cdb_valid), 64'h0);
    chk("rst_tag", 64'(cdb_tag), 64'h0);
    step();
    reset = 1'b0; req_valid = '0;
    step();
    chk("idle_valid", 64'(cdb_valid), 64'h0);

    // Single int branch request
    set_req(0, 6'h05, 32'hDEADBEEF); req_branch = 1'b1; req_taken = 1'b1;
    req_valid = 4'b0001; #1;
    chk("int_grant", 64'(grant), 64'b0001);
    step();
    req_valid = '0; req_branch = 1'b0; req_taken = 1'b0;
    chk("int_valid", 64'(cdb_valid), 64'h1);
    chk("int_tag", 64'(cdb_tag), 64'h05);
    chk("int_data", 64'(cdb_data), 64'hDEADBEEF);
    chk("int_branch", 64'(cdb_branch), 64'h1);
    chk("int_taken", 64'(cdb_taken), 64'h1);
    #1;
    chk("int_nogrant", 64'(grant), 64'h0);
    step();
    chk("int_valid_drop", 64'(cdb_valid), 64'h0);
    chk("int_tag_hold", 64'(cdb_tag), 64'h05);
    chk("int_data_hold", 64'(cdb_data), 64'hDEADBEEF);

    // ls request while the int branch lines are high but int is not valid
    set_req(1, 6'h09, 32'h12345678); req_branch = 1'b1; req_taken = 1'b1;
    req_valid = 4'b0010; #1;
    chk("ls_grant", 64'(grant), 64'b0010);
    step();
    req_valid = '0; req_branch = 1'b0; req_taken = 1'b0;
    chk("ls_valid", 64'(cdb_valid), 64'h1);
    chk("ls_tag", 64'(cdb_tag), 64'h09);
    chk("ls_branch", 64'(cdb_branch), 64'h0);
    chk("ls_taken", 64'(cdb_taken), 64'h0);

    // Async reset pulse between edges to bring ptr back to 0
    #2; reset = 1'b1; #1; reset = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 6'(8'h10 + i), 32'hA0000000 + i);
    req_valid = 4'b1111;
`ifdef CDB_ARB_RR_EN
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("rr_grant%0d", k), 64'(grant), 64'(4'b0001 << (k % 4)));
      step();
      chk($sformatf("rr_valid%0d", k), 64'(cdb_valid), 64'h1);
      chk($sformatf("rr_tag%0d", k), 64'(cdb_tag), 64'(8'h10 + (k % 4)));
    end
`else
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("fp_grant%0d", k), 64'(grant), 64'b1000);
      step();
      chk($sformatf("fp_valid%0d", k), 64'(cdb_valid), 64'h1);
      chk($sformatf("fp_tag%0d", k), 64'(cdb_tag), 64'h13);
    end
`endif
    req_valid = '0;
    step();
    chk("all_drain", 64'(cdb_valid), 64'h0);

    // Reset asserted while a broadcast is on the bus
    set_req(2, 6'h15, 32'hCAFE0015);
    req_valid = 4'b0100; #1;
    chk("mb_grant", 64'(grant), 64'b0100);
    step();
    chk("mb_valid", 64'(cdb_valid), 64'h1);
    chk("mb_tag", 64'(cdb_tag), 64'h15);
    req_valid = 4'b1111;
    #2; reset = 1'b1; #1;
    chk("mb_rst_valid", 64'(cdb_valid), 64'h0);
    chk("mb_rst_tag", 64'(cdb_tag), 64'h0);
    chk("mb_rst_data", 64'(cdb_data), 64'h0);
    chk("mb_rst_grant", 64'(grant), 64'h0);
    req_valid = '0; reset = 1'b0;
    step();
    chk("mb_post_valid0", 64'(cdb_valid), 64'h0);
    step();
    chk("mb_post_valid1", 64'(cdb_valid), 64'h0);

    // A held request loses twice, then is broadcast exactly once
`ifdef CDB_ARB_RR_EN
    set_req(0, 6'h21, 32'h00000021);
    set_req(1, 6'h22, 32'h00000022);
    set_req(2, 6'h2A, 32'h0000002A);
    req_valid = 4'b0111; #1;
    chk("hold_g0", 64'(grant), 64'b0001);
    step();
    chk("hold_t0", 64'(cdb_tag), 64'h21);
    req_valid = 4'b0110; #1;
    chk("hold_g1", 64'(grant), 64'b0010);
    step();
    chk("hold_t1", 64'(cdb_tag), 64'h22);
    req_valid = 4'b0100; #1;
    chk("hold_g2", 64'(grant), 64'b0100);
`else
    set_req(1, 6'h2A, 32'h0000002A);
    set_req(2, 6'h32, 32'h00000032);
    set_req(3, 6'h31, 32'h00000031);
    req_valid = 4'b1110; #1;
    chk("hold_g0", 64'(grant), 64'b1000);
    step();
    chk("hold_t0", 64'(cdb_tag), 64'h31);
    req_valid = 4'b0110; #1;
    chk("hold_g1", 64'(grant), 64'b0100);
    step();
    chk("hold_t1", 64'(cdb_tag), 64'h32);
    req_valid = 4'b0010; #1;
    chk("hold_g2", 64'(grant), 64'b0010);
`endif
    step();
    chk("hold_valid", 64'(cdb_valid), 64'h1);
    chk("hold_tag", 64'(cdb_tag), 64'h2A);
    chk("hold_data", 64'(cdb_data), 64'h2A);
    req_valid = '0;
    step();
    chk("hold_nodup", 64'(cdb_valid), 64'h0);
    chk("hold_tag_keep", 64'(cdb_tag), 64'h2A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
